// File: rtl/ddr_frame_reader.sv
// ddr_frame_reader
//   Streams a completed frame out of DDR2 through one MIG user port into the
//   HDMI pixel path. The MIG read FIFO is kept primed with fixed-length read
//   bursts. A word is popped for each pixel request, and the fetch address
//   wraps at the end of the frame. A frame_start pulse drains whatever is still
//   in flight and then restarts at word 0 of the selected buffer.
//
// Ports
//   clk, reset      pixel/MIG port clock, synchronous active-high reset
//   mem_calib_done  MIG calibration complete
//   base_selector   buffer to display, sampled on frame_start
//   frame_start     one-cycle restart pulse
//   cmd_en/_instr/_bl/_byte_addr   MIG command port (read bursts only)
//   rd_en, rd_data, rd_empty       MIG read FIFO (first-word fall-through)
//   pixel_req       HDMI side asks for one pixel this cycle
//   pixel_data/_valid              registered pixel, one cycle after request
//   underflow       sticky flag: a request found the FIFO empty
module ddr_frame_reader #(
    parameter int unsigned FRAME_WORDS = 1280 * 720,
    parameter int unsigned BURST_LEN   = 32,
    parameter int unsigned FIFO_DEPTH  = 64,
    parameter logic [29:0] FRAME0_BASE = 30'h0,
    parameter logic [29:0] FRAME1_BASE = 30'h400000,
    parameter logic [23:0] UFLOW_RGB   = 24'hFF00FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_calib_done,
    input  logic        base_selector,
    input  logic        frame_start,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    input  logic        rd_empty,
    input  logic        pixel_req,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic        underflow
);

    localparam int unsigned      IDX_W     = $clog2(FRAME_WORDS + 1);
    localparam logic [IDX_W-1:0] BURST_IDX = IDX_W'(BURST_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_WORDS - BURST_LEN);
    localparam logic [6:0]       BURST_CNT = 7'(BURST_LEN);

    typedef enum logic [1:0] {WAIT_CAL, FETCH, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [29:0]      base;
    logic [IDX_W-1:0] fetch_idx;
    logic [6:0]       outstanding;
    logic             cmd_q;
    logic             cmd_fire, base_load, idx_clear, cnt_clear, room;
    logic [7:0]       cnt_after_cmd;
    logic             unused_rd_bits;

    function automatic logic [29:0] word_addr(input logic [29:0] b, input logic [IDX_W-1:0] idx);
        return b + (30'(idx) << 2);
    endfunction

    assign cmd_instr      = 3'b001;
    assign cmd_bl         = 6'(BURST_LEN - 1);
    // Address is loaded the cycle before the strobe. Gating with calibration
    // keeps a strobe from escaping in the cycle calibration is lost.
    assign cmd_en         = cmd_q & mem_calib_done;
    assign cnt_after_cmd  = {1'b0, outstanding} + 8'(BURST_LEN);
    assign room           = (cnt_after_cmd <= 8'(FIFO_DEPTH));
    assign unused_rd_bits = ^rd_data[31:24];

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        cmd_fire  = 1'b0;
        base_load = 1'b0;
        idx_clear = 1'b0;
        cnt_clear = 1'b0;
        case (state)
            WAIT_CAL: begin
                if (frame_start) begin
                    base_load = 1'b1;
                    idx_clear = 1'b1;
                end
                if (mem_calib_done) state_nxt = FETCH;
            end
            FETCH: begin
                rd_en = pixel_req & ~rd_empty;
                if (!mem_calib_done) begin
                    state_nxt = WAIT_CAL;
                    cnt_clear = 1'b1;
                    idx_clear = 1'b1;
                end else if (frame_start) begin
                    state_nxt = DRAIN;
                    base_load = 1'b1;
                end else if (!cmd_q && room) begin
                    // cmd_q low here spaces commands at least two cycles apart
                    cmd_fire = 1'b1;
                end
            end
            DRAIN: begin
                rd_en = ~rd_empty;
                if (!mem_calib_done) begin
                    state_nxt = WAIT_CAL;
                    cnt_clear = 1'b1;
                    idx_clear = 1'b1;
                end else begin
                    if (frame_start) base_load = 1'b1;
                    if (outstanding == 7'd0 && !cmd_q) begin
                        idx_clear = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            default: state_nxt = WAIT_CAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_CAL;
            cmd_q         <= 1'b0;
            cmd_byte_addr <= 30'h0;
            fetch_idx     <= '0;
            outstanding   <= 7'd0;
            base          <= FRAME0_BASE;
            pixel_data    <= 24'h0;
            pixel_valid   <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            state <= state_nxt;
            cmd_q <= cmd_fire;

            if (cmd_fire) cmd_byte_addr <= word_addr(base, fetch_idx);

            if (idx_clear)     fetch_idx <= '0;
            else if (cmd_fire) fetch_idx <= (fetch_idx == LAST_IDX) ? '0 : fetch_idx + BURST_IDX;

            if (base_load) base <= base_selector ? FRAME1_BASE : FRAME0_BASE;

            if (cnt_clear) outstanding <= 7'd0;
            else           outstanding <= outstanding + (cmd_en ? BURST_CNT : 7'd0) - (rd_en ? 7'd1 : 7'd0);

            // Outside FETCH, and on an empty FIFO, the request is answered with the filler colour
            pixel_valid <= pixel_req;
            if (pixel_req) pixel_data <= (state == FETCH && !rd_empty) ? rd_data[23:0] : UFLOW_RGB;

            if (frame_start) underflow <= 1'b0;
            else if (state == FETCH && pixel_req && rd_empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_frame_reader.sv
module tb_ddr_frame_reader;

    localparam int FW  = 256;
    localparam int BL  = 32;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_calib_done = 1'b0;
    logic        base_selector = 1'b0;
    logic        frame_start = 1'b0;
    logic        pixel_req = 1'b0;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        rd_en;
    logic [31:0] rd_data = 32'h0;
    logic        rd_empty = 1'b1;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        underflow;

    always #5 clk = ~clk;

    ddr_frame_reader #(
        .FRAME_WORDS(FW),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (64),
        .FRAME0_BASE(30'h0),
        .FRAME1_BASE(30'h400000),
        .UFLOW_RGB  (24'hFF00FF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_calib_done(mem_calib_done),
        .base_selector (base_selector),
        .frame_start   (frame_start),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_byte_addr (cmd_byte_addr),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_empty      (rd_empty),
        .pixel_req     (pixel_req),
        .pixel_data    (pixel_data),
        .pixel_valid   (pixel_valid),
        .underflow     (underflow)
    );

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_pix[$];
    logic [29:0] exp_cmd[$];

    // MIG port model: each read word carries its own word address, tagged high byte
    logic [31:0] mig_fifo[$];
    logic [31:0] pend_d[$];
    int          pend_t[$];
    int          cyc = 0;
    int          pops = 0;
    bit          withhold = 1'b0;
    logic [31:0] dummy_d;
    int          dummy_t;

    always @(posedge clk) begin
        if (reset || !mem_calib_done) begin
            mig_fifo.delete();
            pend_d.delete();
            pend_t.delete();
        end else begin
            if (rd_en && mig_fifo.size() > 0) begin
                dummy_d = mig_fifo.pop_front();
                pops++;
            end
            if (cmd_en) begin
                for (int i = 0; i < BL; i++) begin
                    pend_d.push_back({8'hA5, 24'((cmd_byte_addr >> 2) + 30'(i))});
                    pend_t.push_back(cyc + LAT);
                end
            end
            while (!withhold && pend_t.size() > 0 && pend_t[0] <= cyc) begin
                mig_fifo.push_back(pend_d.pop_front());
                dummy_t = pend_t.pop_front();
            end
        end
        rd_empty <= (mig_fifo.size() == 0);
        rd_data  <= (mig_fifo.size() > 0) ? mig_fifo[0] : 32'h0;
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (pixel_valid === 1'b1) begin
            if (exp_pix.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pixel_unexpected: got %0h expected none", pixel_data);
            end else begin
                check("pixel", 64'(pixel_data), 64'(exp_pix.pop_front()));
            end
        end
        if (cmd_en === 1'b1) begin
            if (exp_cmd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected: got addr %0h expected none", cmd_byte_addr);
            end else begin
                check("cmd", 64'({cmd_instr, cmd_bl, cmd_byte_addr}), 64'({3'b001, 6'd31, exp_cmd.pop_front()}));
            end
            check("cmd_calib", 64'(mem_calib_done), 64'd1);
        end
        if (rd_en === 1'b1) check("rd_en_empty", 64'(rd_empty), 64'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic stream(input int n, input logic [23:0] first);
        for (int i = 0; i < n; i++) begin
            pixel_req = 1'b1;
            exp_pix.push_back(first + 24'(i));
            tick();
        end
        pixel_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_en"}, 64'(cmd_en), 64'd0);
        check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        check({tag, "_addr"}, 64'(cmd_byte_addr), 64'd0);
        check({tag, "_pixel_data"}, 64'(pixel_data), 64'd0);
        check({tag, "_pixel_valid"}, 64'(pixel_valid), 64'd0);
        check({tag, "_underflow"}, 64'(underflow), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int p0;
        bit got;

        idle(3);
        check_reset_outputs("reset");

        // Uncalibrated: no commands, filler pixel without raising underflow
        reset = 1'b0;
        idle(50);
        pixel_req = 1'b1;
        exp_pix.push_back(24'hFF00FF);
        tick();
        pixel_req = 1'b0;
        idle(50);
        check("uflow_wait_cal", 64'(underflow), 64'd0);

        // Priming: exactly two bursts fill the FIFO
        exp_cmd.push_back(30'h0);
        exp_cmd.push_back(30'h80);
        mem_calib_done = 1'b1;
        idle(60);
        check("prime_cmds", 64'(exp_cmd.size()), 64'd0);

        // Full frame streamed in order, fetch address wraps to frame 0 start
        for (int i = 2; i < FW / BL; i++) exp_cmd.push_back(30'(i * BL * 4));
        exp_cmd.push_back(30'h0);
        exp_cmd.push_back(30'h80);
        stream(FW, 24'h0);
        idle(40);
        check("frame_uflow", 64'(underflow), 64'd0);
        check("frame_cmds", 64'(exp_cmd.size()), 64'd0);
        check("frame_pixels", 64'(exp_pix.size()), 64'd0);

        // Switch to frame 1 with 40 words outstanding
        stream(24, 24'h0);
        p0 = pops;
        base_selector = 1'b1;
        exp_cmd.push_back(30'h400000);
        exp_cmd.push_back(30'h400080);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        idle(80);
        check("drain_pops", 64'(pops - p0), 64'd40);
        check("drain_cmds", 64'(exp_cmd.size()), 64'd0);
        stream(1, 24'h100000);
        idle(5);

        // Data withheld: drain the FIFO, then requests underflow
        withhold = 1'b1;
        exp_cmd.push_back(30'h400100);
        exp_cmd.push_back(30'h400180);
        stream(63, 24'h100001);
        for (int i = 0; i < 3; i++) begin
            pixel_req = 1'b1;
            exp_pix.push_back(24'hFF00FF);
            check("uflow_rd_en", 64'(rd_en), 64'd0);
            tick();
        end
        pixel_req = 1'b0;
        check("uflow_set", 64'(underflow), 64'd1);
        idle(20);
        check("uflow_cmds", 64'(exp_cmd.size()), 64'd0);

        base_selector = 1'b0;
        exp_cmd.push_back(30'h0);
        exp_cmd.push_back(30'h80);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("uflow_clear", 64'(underflow), 64'd0);
        pixel_req = 1'b1;
        exp_pix.push_back(24'hFF00FF);
        tick();
        pixel_req = 1'b0;
        tick();
        check("uflow_drain", 64'(underflow), 64'd0);
        withhold = 1'b0;
        idle(100);
        check("restart_cmds", 64'(exp_cmd.size()), 64'd0);

        // Reset landing on a command cycle
        exp_cmd.push_back(30'h100);
        stream(32, 24'h0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (cmd_en) got = 1'b1;
        end
        check("cmd_before_reset", 64'(got), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        tick();
        reset = 1'b0;
        exp_cmd.push_back(30'h0);
        exp_cmd.push_back(30'h80);
        idle(60);
        check("post_reset_cmds", 64'(exp_cmd.size()), 64'd0);
        check("pixels_drained", 64'(exp_pix.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
